// File: rtl/rip_csr_ctrl_pkg.sv
//==============================================================================
// Module  : rip_csr_ctrl_pkg
// Brief   : Shared types, CSR addresses and access helpers for rip_csr_ctrl.
// Revision: 1.0
//==============================================================================
`default_nettype none

package rip_csr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_TRAP_REDIR = 2'd1,
        ST_MRET_REDIR = 2'd2,
        ST_CSR_RESP   = 2'd3
    } csr_ctrl_state_t;

    typedef enum logic [1:0] {
        CSR_READ = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    typedef struct packed {
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] cycle;
    } csr_t;

    typedef struct packed {
        logic [31:0] tp;
        logic [31:0] tn;
        logic [31:0] fp;
        logic [31:0] fn;
    } bp_cnt_t;

    localparam logic [11:0] CSR_ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_ADDR_CYCLE  = 12'hC00;
    localparam logic [11:0] CSR_ADDR_BPTP   = 12'h7C0;
    localparam logic [11:0] CSR_ADDR_BPTN   = 12'h7C1;
    localparam logic [11:0] CSR_ADDR_BPFP   = 12'h7C2;
    localparam logic [11:0] CSR_ADDR_BPFN   = 12'h7C3;

    function automatic logic [31:0] csr_read(input csr_t regs, input bp_cnt_t bp,
                                             input logic [11:0] num);
        logic [31:0] val;
        val = '0;
        case (num)
            CSR_ADDR_MTVEC:  val = regs.mtvec;
            CSR_ADDR_MEPC:   val = regs.mepc;
            CSR_ADDR_MCAUSE: val = regs.mcause;
            CSR_ADDR_CYCLE:  val = regs.cycle;
            CSR_ADDR_BPTP:   val = bp.tp;
            CSR_ADDR_BPTN:   val = bp.tn;
            CSR_ADDR_BPFP:   val = bp.fp;
            CSR_ADDR_BPFN:   val = bp.fn;
            default:         val = '0;
        endcase
        return val;
    endfunction

    function automatic logic [31:0] csr_wval(input csr_op_t op, input logic [31:0] old,
                                             input logic [31:0] wdata);
        logic [31:0] val;
        case (op)
            CSR_RW:  val = wdata;
            CSR_RS:  val = old | wdata;
            CSR_RC:  val = old & ~wdata;
            default: val = old;
        endcase
        return val;
    endfunction

    // Counters and unknown addresses fall through untouched.
    function automatic csr_t csr_write(input csr_t regs, input logic [11:0] num,
                                       input logic [31:0] val);
        csr_t r;
        r = regs;
        case (num)
            CSR_ADDR_MTVEC:  r.mtvec  = val;
            CSR_ADDR_MEPC:   r.mepc   = val;
            CSR_ADDR_MCAUSE: r.mcause = val;
            default:         r = regs;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rip_bp_counters.sv
//==============================================================================
// Module  : rip_bp_counters
// Brief   : Branch prediction outcome counters (TP/TN/FP/FN), 32-bit wrapping.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rip_bp_counters
    import rip_csr_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    update_valid_i,
    input  logic    pred_taken_i,
    input  logic    taken_i,
    output bp_cnt_t cnt_o
);

    bp_cnt_t cnt_q;
    bp_cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (update_valid_i) begin
            case ({pred_taken_i, taken_i})
                2'b11:   cnt_d.tp = cnt_q.tp + 32'd1;
                2'b00:   cnt_d.tn = cnt_q.tn + 32'd1;
                2'b10:   cnt_d.fp = cnt_q.fp + 32'd1;
                default: cnt_d.fn = cnt_q.fn + 32'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/rip_csr_ctrl.sv
//==============================================================================
// Module  : rip_csr_ctrl
// Brief   : Machine CSR owner: arbitrates trap/mret/CSR access, drives fetch
//           redirect. Optional macro RIP_BP_COUNTERS_EN adds the bp counters.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rip_csr_ctrl
    import rip_csr_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] RESET_MEPC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_num,
    input  logic [31:0] csr_wdata,
    output logic        csr_rvalid,
    output logic [31:0] csr_rdata,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    output logic        trap_ack,
    input  logic        mret_valid,
    output logic        mret_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        bp_update_valid,
    input  logic        bp_pred_taken,
    input  logic        bp_taken
);

    csr_ctrl_state_t state_q, state_d;
    csr_t            csr_q, csr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     old_val;
    bp_cnt_t         bp_cnt;

`ifdef RIP_BP_COUNTERS_EN
    rip_bp_counters u_bp_counters (
        .clk            (clk),
        .rstn           (rstn),
        .update_valid_i (bp_update_valid),
        .pred_taken_i   (bp_pred_taken),
        .taken_i        (bp_taken),
        .cnt_o          (bp_cnt)
    );
`else
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{bp_update_valid, bp_pred_taken, bp_taken};
    assign bp_cnt           = '0;
`endif

    assign old_val = csr_read(csr_q, bp_cnt, csr_num);

    always_comb begin
        state_d       = state_q;
        csr_d         = csr_q;
        csr_d.cycle   = csr_q.cycle + 32'd1;
        rdata_d       = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_valid) begin
                    csr_d.mepc   = trap_pc;
                    csr_d.mcause = trap_cause;
                    state_d      = ST_TRAP_REDIR;
                end else if (mret_valid) begin
                    state_d = ST_MRET_REDIR;
                end else if (csr_req_valid) begin
                    rdata_d = old_val;
                    if (csr_op_t'(csr_op) != CSR_READ) begin
                        csr_d = csr_write(csr_d, csr_num,
                                          csr_wval(csr_op_t'(csr_op), old_val, csr_wdata));
                    end
                    state_d = ST_CSR_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            csr_q.mtvec  <= RESET_MTVEC;
            csr_q.mepc   <= RESET_MEPC;
            csr_q.mcause <= '0;
            csr_q.cycle  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            csr_q   <= csr_d;
            rdata_q <= rdata_d;
        end
    end

    // Gated by rstn so every output reads 0 while reset is held.
    assign csr_req_ready  = rstn && (state_q == ST_IDLE) && !trap_valid && !mret_valid;
    assign trap_ack       = (state_q == ST_TRAP_REDIR);
    assign mret_ack       = (state_q == ST_MRET_REDIR);
    assign redirect_valid = trap_ack || mret_ack;
    assign redirect_pc    = trap_ack ? {csr_q.mtvec[31:2], 2'b00} :
                            mret_ack ? csr_q.mepc : 32'h0;
    assign csr_rvalid     = (state_q == ST_CSR_RESP);
    assign csr_rdata      = csr_rvalid ? rdata_q : 32'h0;

endmodule

`default_nettype wire
